// File: rtl/i2c_slave_engine.sv
// rtl/i2c_slave_engine.sv - I2C slave byte engine; clock stretching enabled by I2C_SLAVE_CLK_STRETCH_EN
module i2c_slave_engine #(
    parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_seen
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_RX_BYTE  = 3'd3;
    localparam logic [2:0] S_RX_ACK   = 3'd4;
    localparam logic [2:0] S_TX_BYTE  = 3'd5;
    localparam logic [2:0] S_TX_ACK   = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;
    logic [2:0] sync_vld;

    logic       scl_s;
    logic       sda_s;
    logic       armed;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       tx_enter;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       byte_done;
    logic       rw;
    logic       load_pending;

    // Two-flop synchronizers plus one history stage for edge detection; reset to idle-bus level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            sync_vld <= 3'b000;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    // Edge/condition detection is masked until the pipeline holds real pin samples,
    // so a bus caught mid-transfer at reset release cannot fake a START.
    always_comb begin
        scl_s     = scl_sync[1];
        sda_s     = sda_sync[1];
        armed     = sync_vld[2];
        scl_rise  = armed &  scl_s & ~scl_q;
        scl_fall  = armed & ~scl_s &  scl_q;
        start_det = armed &  scl_s &  scl_q &  sda_q & ~sda_s;
        stop_det  = armed &  scl_s &  scl_q & ~sda_q &  sda_s;
        tx_enter  = scl_fall & (((state == S_ADDR_ACK) & rw) |
                                ((state == S_TX_ACK) & byte_done));
    end

    // Protocol FSM: START/STOP override everything, otherwise act on SCL edges per state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            bit_cnt      <= 3'd0;
            shreg        <= 8'h00;
            byte_done    <= 1'b0;
            rw           <= 1'b0;
            load_pending <= 1'b0;
            sda_oe       <= 1'b0;
            scl_oe       <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            tx_req       <= 1'b0;
            busy         <= 1'b0;
            nack_seen    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            nack_seen <= 1'b0;
            if (stop_det) begin
                state        <= S_IDLE;
                sda_oe       <= 1'b0;
                scl_oe       <= 1'b0;
                busy         <= 1'b0;
                byte_done    <= 1'b0;
                load_pending <= 1'b0;
            end else if (start_det) begin
                state        <= S_ADDR;
                bit_cnt      <= 3'd0;
                sda_oe       <= 1'b0;
                scl_oe       <= 1'b0;
                byte_done    <= 1'b0;
                load_pending <= 1'b0;
            end else if (tx_enter) begin
                // Falling edge ending an ACK slot of a read: hand out the next byte
                state     <= S_TX_BYTE;
                tx_req    <= 1'b1;
                byte_done <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                if (!tx_ready) begin
                    sda_oe       <= 1'b0;
                    scl_oe       <= 1'b1;
                    load_pending <= 1'b1;
                end else
`endif
                begin
                    shreg  <= tx_data;
                    sda_oe <= ~tx_data[7];
                end
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                                rw        <= sda_s;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= S_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        // Read direction is taken by tx_enter; only the write path remains
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= S_RX_BYTE;
                        end
                    end
                    S_RX_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shreg[6:0], sda_s};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= S_RX_BYTE;
                        end
                    end
                    S_TX_BYTE: begin
                        if (load_pending) begin
                            // SCL is held low here, so driving the first bit is safe
                            if (tx_ready) begin
                                shreg        <= tx_data;
                                sda_oe       <= ~tx_data[7];
                                scl_oe       <= 1'b0;
                                load_pending <= 1'b0;
                            end
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                sda_oe    <= 1'b0;
                                state     <= S_TX_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    S_TX_ACK: begin
                        // Master ACK (0) arms a reload on the next fall; NACK ends our part
                        if (scl_rise) begin
                            if (sda_s) begin
                                nack_seen <= 1'b1;
                                state     <= S_IGNORE;
                            end else begin
                                byte_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
